// File: rtl/mnist_lut_pkg.sv
// Shared constants and types for the MNIST LUT network output stages.
// count_width() sizes a counter that must hold values 0..frame_num.
package mnist_lut_pkg;

  localparam int MNIST_CLASS_NUM   = 10;
  localparam int MNIST_USER_WIDTH  = 8;
  localparam int MNIST_CLASS_WIDTH = 4;

  typedef logic [MNIST_CLASS_WIDTH-1:0] class_idx_t;

  function automatic int count_width(input int frame_num);
    int w;
    w = 1;
    while ((1 << w) <= frame_num) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/mnist_lut_argmax.sv
// Combinational CLASS_NUM-way maximum search over packed counts.
// Only a strictly larger count displaces the current best, so ties keep the lowest index.
module mnist_lut_argmax
  import mnist_lut_pkg::*;
#(
  parameter int CLASS_NUM   = MNIST_CLASS_NUM,
  parameter int CLASS_WIDTH = MNIST_CLASS_WIDTH,
  parameter int COUNT_WIDTH = 3
) (
  input  logic [CLASS_NUM-1:0][COUNT_WIDTH-1:0] counts,
  output logic [CLASS_WIDTH-1:0]                max_class,
  output logic [COUNT_WIDTH-1:0]                max_count
);

  always_comb begin
    max_class = '0;
    max_count = counts[0];
    for (int i = 1; i < CLASS_NUM; i++) begin
      if (counts[i] > max_count) begin
        max_class = CLASS_WIDTH'(i);
        max_count = counts[i];
      end
    end
  end

endmodule

// File: rtl/mnist_lut_result_voter.sv
// Majority voter over FRAME_NUM binary-modulated frames per image.
// Optional MNIST_LUT_VOTER_MATCH_EN adds out_match and match_count.
module mnist_lut_result_voter
  import mnist_lut_pkg::*;
#(
  parameter int USER_WIDTH  = MNIST_USER_WIDTH,
  parameter int CLASS_NUM   = MNIST_CLASS_NUM,
  parameter int FRAME_NUM   = 7,
  parameter int CLASS_WIDTH = MNIST_CLASS_WIDTH,
  parameter int COUNT_WIDTH = count_width(FRAME_NUM)
) (
  input  logic                   reset,
  input  logic                   clk,
  input  logic                   cke,
  input  logic [USER_WIDTH-1:0]  in_user,
  input  logic [CLASS_NUM-1:0]   in_data,
  input  logic                   in_valid,
  output logic [USER_WIDTH-1:0]  out_user,
  output logic [CLASS_WIDTH-1:0] out_class,
  output logic [COUNT_WIDTH-1:0] out_count,
  output logic                   out_valid
`ifdef MNIST_LUT_VOTER_MATCH_EN
  ,
  output logic                   out_match,
  output logic [31:0]            match_count
`endif
);

  localparam int FCW = 8;

  logic [FCW-1:0]                       frame_cnt;
  logic [CLASS_NUM-1:0][COUNT_WIDTH-1:0] acc;
  logic [CLASS_NUM-1:0][COUNT_WIDTH-1:0] acc_nxt;
  logic [CLASS_NUM-1:0][COUNT_WIDTH-1:0] snap;
  logic [USER_WIDTH-1:0]                grp_user;
  logic [USER_WIDTH-1:0]                snap_user;
  logic                                 snap_valid;
  logic                                 first;
  logic                                 last;
  logic [CLASS_WIDTH-1:0]               win_class;
  logic [COUNT_WIDTH-1:0]               win_count;

  assign first = frame_cnt == '0;
  assign last  = frame_cnt == FCW'(FRAME_NUM - 1);

  // First sample of a group loads rather than adds.
  always_comb begin
    acc_nxt = '0;
    for (int i = 0; i < CLASS_NUM; i++)
      acc_nxt[i] = (first ? '0 : acc[i]) + COUNT_WIDTH'(in_data[i]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_cnt  <= '0;
      acc        <= '0;
      snap       <= '0;
      grp_user   <= '0;
      snap_user  <= '0;
      snap_valid <= 1'b0;
    end else if (cke) begin
      snap_valid <= 1'b0;
      if (in_valid) begin
        acc <= acc_nxt;
        if (first) grp_user <= in_user;
        if (last) begin
          snap       <= acc_nxt;
          snap_user  <= first ? in_user : grp_user;
          snap_valid <= 1'b1;
          frame_cnt  <= '0;
        end else begin
          frame_cnt <= frame_cnt + FCW'(1);
        end
      end
    end
  end

  mnist_lut_argmax #(
    .CLASS_NUM  (CLASS_NUM),
    .CLASS_WIDTH(CLASS_WIDTH),
    .COUNT_WIDTH(COUNT_WIDTH)
  ) u_argmax (
    .counts   (snap),
    .max_class(win_class),
    .max_count(win_count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_class <= '0;
      out_count <= '0;
      out_user  <= '0;
    end else if (cke) begin
      out_valid <= snap_valid;
      if (snap_valid) begin
        out_class <= win_class;
        out_count <= win_count;
        out_user  <= snap_user;
      end
    end
  end

`ifdef MNIST_LUT_VOTER_MATCH_EN
  logic win_match;

  assign win_match = win_class == snap_user[CLASS_WIDTH-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_match   <= 1'b0;
      match_count <= '0;
    end else if (cke && snap_valid) begin
      out_match <= win_match;
      if (win_match) match_count <= match_count + 32'd1;
    end
  end
`endif

endmodule
